// File: rtl/pu_riscv_if_queue.sv
// Instruction-fetch queue: owns the fetch PC, issues in-order imem requests and buffers parcels for decode.
// Optional feature macro: PU_RISCV_IF_BPREDICT_EN (honour bp_predict/bp_nxt_pc).
module pu_riscv_if_queue #(
  parameter int unsigned     XLEN           = 64,
  parameter int unsigned     ILEN           = 32,
  parameter int unsigned     DEPTH          = 4,
  parameter logic [XLEN-1:0] PC_INIT        = 'h200,
  parameter int unsigned     EXCEPTION_SIZE = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  output logic                      imem_req,
  output logic [XLEN-1:0]           imem_adr,
  input  logic                      imem_ack,
  input  logic                      imem_parcel_valid,
  input  logic [ILEN-1:0]           imem_parcel,
  input  logic                      imem_parcel_error,
  input  logic [1:0]                bp_predict,
  input  logic [XLEN-1:0]           bp_nxt_pc,
  input  logic                      bu_flush,
  input  logic                      st_flush,
  input  logic                      du_flush,
  input  logic [XLEN-1:0]           bu_nxt_pc,
  input  logic [XLEN-1:0]           st_nxt_pc,
  input  logic                      id_stall,
  output logic [XLEN-1:0]           if_pc,
  output logic [ILEN-1:0]           if_instr,
  output logic                      if_bubble,
  output logic [1:0]                if_bp_predict,
  output logic [EXCEPTION_SIZE-1:0] if_exception
);

  localparam int unsigned               PW           = $clog2(DEPTH);
  localparam int unsigned               CW           = PW + 1;
  localparam logic [CW:0]               DEPTH_W      = (CW+1)'(DEPTH);
  localparam logic [ILEN-1:0]           NOP          = ILEN'(32'h0000_0013);
  localparam logic [EXCEPTION_SIZE-1:0] EXC_MISALIGN = EXCEPTION_SIZE'(1);
  localparam logic [EXCEPTION_SIZE-1:0] EXC_ACCESS   = EXCEPTION_SIZE'(2);

  logic [XLEN-1:0]           fetch_pc;
  logic [CW-1:0]             outstanding;
  logic [CW-1:0]             discard;
  logic [CW-1:0]             fifo_count;
  logic                      halt;
  logic [PW-1:0]             wr_ptr, rd_ptr, req_wr_ptr, req_rd_ptr;

  logic [XLEN-1:0]           fifo_pc    [DEPTH];
  logic [ILEN-1:0]           fifo_instr [DEPTH];
  logic [1:0]                fifo_pred  [DEPTH];
  logic [EXCEPTION_SIZE-1:0] fifo_exc   [DEPTH];
  logic [XLEN-1:0]           req_pc_q   [DEPTH];
  logic [1:0]                req_pred_q [DEPTH];

  logic                      flush_any, credit, aligned, accept;
  logic                      resp_keep, misalign_push, push, pop, push_fault;
  logic [XLEN-1:0]           next_pc, push_pc;
  logic [ILEN-1:0]           push_instr;
  logic [1:0]                push_pred, req_pred_in;
  logic [EXCEPTION_SIZE-1:0] push_exc;

  assign flush_any     = st_flush | bu_flush | du_flush;
  assign credit        = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_W;
  assign aligned       = (fetch_pc[1:0] == 2'b00);
  assign imem_req      = rstn & ~halt & ~flush_any & credit & aligned;
  assign imem_adr      = fetch_pc;
  assign accept        = imem_req & imem_ack;
  assign resp_keep     = rstn & imem_parcel_valid & (discard == '0) & ~flush_any;
  // Misaligned entry waits for all in-flight responses so queue order is preserved
  assign misalign_push = rstn & ~halt & ~flush_any & ~aligned & credit &
                         (outstanding == '0) & ~imem_parcel_valid;
  assign push          = resp_keep | misalign_push;
  assign pop           = rstn & ~id_stall & ~flush_any & (fifo_count != '0);
  assign push_fault    = misalign_push | (resp_keep & imem_parcel_error);

`ifdef PU_RISCV_IF_BPREDICT_EN
  assign next_pc     = bp_predict[1] ? bp_nxt_pc : fetch_pc + XLEN'(4);
  assign req_pred_in = bp_predict;
`else
  logic unused_bp;
  assign unused_bp   = ^{bp_predict, bp_nxt_pc};
  assign next_pc     = fetch_pc + XLEN'(4);
  assign req_pred_in = 2'b00;
`endif

  // Entry to push: returned parcel (tagged with its request) or a synthetic misaligned NOP
  always_comb begin
    push_pc    = fetch_pc;
    push_instr = NOP;
    push_pred  = 2'b00;
    push_exc   = EXC_MISALIGN;
    if (resp_keep) begin
      push_pc    = req_pc_q[req_rd_ptr];
      push_instr = imem_parcel_error ? NOP : imem_parcel;
      push_pred  = req_pred_q[req_rd_ptr];
      push_exc   = imem_parcel_error ? EXC_ACCESS : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_pc_q[req_wr_ptr]   <= fetch_pc;
      req_pred_q[req_wr_ptr] <= req_pred_in;
    end
    if (push) begin
      fifo_pc[wr_ptr]    <= push_pc;
      fifo_instr[wr_ptr] <= push_instr;
      fifo_pred[wr_ptr]  <= push_pred;
      fifo_exc[wr_ptr]   <= push_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc      <= PC_INIT;
      outstanding   <= '0;
      discard       <= '0;
      fifo_count    <= '0;
      halt          <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      req_wr_ptr    <= '0;
      req_rd_ptr    <= '0;
      if_pc         <= PC_INIT;
      if_instr      <= NOP;
      if_bubble     <= 1'b1;
      if_bp_predict <= 2'b00;
      if_exception  <= '0;
    end else begin
      if (st_flush)      fetch_pc <= st_nxt_pc;
      else if (bu_flush) fetch_pc <= bu_nxt_pc;
      else if (accept)   fetch_pc <= next_pc;

      // Request tags stay in step with the bus, doomed or not
      if (accept)            req_wr_ptr <= req_wr_ptr + PW'(1);
      if (imem_parcel_valid) req_rd_ptr <= req_rd_ptr + PW'(1);
      case ({accept, imem_parcel_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase

      if (flush_any)                               discard <= outstanding - CW'(imem_parcel_valid);
      else if (imem_parcel_valid && discard != '0) discard <= discard - CW'(1);

      if (flush_any)       halt <= 1'b0;
      else if (push_fault) halt <= 1'b1;

      if (flush_any) begin
        fifo_count <= '0;
        wr_ptr     <= rd_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CW'(1);
          2'b01:   fifo_count <= fifo_count - CW'(1);
          default: ;
        endcase
      end

      // Decode bundle: bubble on flush, pop when decode accepts
      if (flush_any) begin
        if_bubble     <= 1'b1;
        if_instr      <= NOP;
        if_bp_predict <= 2'b00;
        if_exception  <= '0;
      end else if (!id_stall) begin
        if (fifo_count != '0) begin
          if_pc         <= fifo_pc[rd_ptr];
          if_instr      <= fifo_instr[rd_ptr];
          if_bp_predict <= fifo_pred[rd_ptr];
          if_exception  <= fifo_exc[rd_ptr];
          if_bubble     <= 1'b0;
        end else begin
          if_bubble     <= 1'b1;
          if_instr      <= NOP;
          if_bp_predict <= 2'b00;
          if_exception  <= '0;
        end
      end
    end
  end

endmodule

// File: doc/pu_riscv_if_queue.md
# pu_riscv_if_queue

Instruction-fetch queue for the PU-RISCV core, sitting directly upstream of the instruction decoder. It owns the fetch PC and issues in-order requests to the instruction memory interface. Returned parcels are buffered in a small FIFO and presented to decode on the `if_pc`/`if_instr`/`if_bubble`/`if_bp_predict`/`if_exception` bundle. It honours decode stalls and branch/trap/debug flushes, discarding in-flight responses after a redirect.

## Interface
- `XLEN`, 64, address/PC width
- `ILEN`, 32, instruction width
- `DEPTH`, 4, FIFO entries and maximum outstanding requests (power of 2, ≥2)
- `PC_INIT`, `'h200`, fetch PC after reset
- `EXCEPTION_SIZE`, 16, width of exception vector; bit 0 = instruction-misaligned, bit 1 = instruction-access-fault
- `clk` in 1 — single clock; all state updates on rising edge
- `rstn` in 1 — reset, synchronous, active-low
- `imem_req` out 1 — fetch request valid
- `imem_adr` out XLEN — fetch address (= fetch PC)
- `imem_ack` in 1 — request accepted this cycle
- `imem_parcel_valid` in 1 — in-order response valid
- `imem_parcel` in ILEN — response instruction
- `imem_parcel_error` in 1 — bus error on this response
- `bp_predict` in 2 — predictor result for `imem_adr`; bit 1 = taken
- `bp_nxt_pc` in XLEN — predicted target
- `bu_flush`, `st_flush`, `du_flush` in 1 — branch, state/trap, debug flush
- `bu_nxt_pc`, `st_nxt_pc` in XLEN — redirect targets
- `id_stall` in 1 — decode cannot accept
- `if_pc` out XLEN, `if_instr` out ILEN, `if_bubble` out 1, `if_bp_predict` out 2, `if_exception` out EXCEPTION_SIZE — registered decode bundle

## Operation
- State: `fetch_pc`; FIFO of {pc, instr, predict, exception}; `outstanding` counter (0..DEPTH, includes doomed requests); `discard` counter; `halt` flag.
- Issue: `imem_req = !halt && !du_flush && !flush_any && (fifo_count + outstanding < DEPTH) && fetch_pc[1:0]==0`.
- On accept (`imem_req && imem_ack`):
  - `outstanding++`.
  - Record `bp_predict` in a side FIFO with the request.
  - `fetch_pc <= bp_predict[1] ? bp_nxt_pc : fetch_pc+4`.
- Response:
  - `outstanding--`.
  - If `discard>0`: `discard--` and drop.
  - Otherwise push {pc, parcel, predict, access-fault=`imem_parcel_error`}.
  - An error entry has instr forced to NOP `32'h00000013` and sets `halt`.
- Misaligned `fetch_pc` (bits[1:0]≠0) with `!halt` and FIFO space:
  - Push {fetch_pc, NOP, 2'b00, bit0} without a bus request.
  - Set `halt`.
- Flush priority: `st_flush` > `bu_flush`; `du_flush` clears only.
  - FIFO cleared.
  - `discard <= outstanding − (response this cycle)`.
  - `halt` cleared.
  - `fetch_pc <= st_flush ? st_nxt_pc : bu_nxt_pc` (unchanged for `du_flush` alone).
  - Next-cycle outputs: `if_bubble=1`.
  - While `du_flush` is held: no issue.
- Output register, when `!id_stall` and no flush:
  - If FIFO not empty: pop head into `if_*`, `if_bubble=0`.
  - Else: `if_bubble=1`, `if_instr=NOP`, `if_exception=0`, `if_pc` holds.
- `id_stall` holds all `if_*` outputs and blocks pop; push/issue continue while credit remains.
- Full FIFO plus `outstanding` equal to DEPTH: issue stops; no response is ever dropped for lack of space.

## Timing
- Reset values:
  - `if_bubble=1`, `if_instr=32'h00000013`, `if_pc=PC_INIT`, `if_bp_predict=0`, `if_exception=0`.
  - `imem_req=0`, `imem_adr=PC_INIT`.
  - Counters 0, `halt=0`.
- First `imem_req` is asserted in the first cycle with `rstn=1`.
- Reset mid-operation: all state is dropped; the memory side is reset alongside, so no pre-reset responses arrive.
- Latency: a response valid in cycle T enters the FIFO at the end of T and is visible on `if_*` in T+2 (empty queue, no stall).
- Flush in cycle T:
  - `if_bubble=1` in T+1.
  - `imem_req` at the new PC no earlier than T+1.
  - A response in cycle T is discarded.
- Simultaneous accept and response: `outstanding` is unchanged.
- Simultaneous push and pop: `fifo_count` is unchanged.
- PC arithmetic wraps modulo 2^XLEN.

## Configuration
- `PU_RISCV_IF_BPREDICT_EN` defined: `bp_predict`/`bp_nxt_pc` are honoured as above.
- Undefined:
  - Next PC is always `fetch_pc+4`.
  - Stored and output `if_bp_predict` are `2'b00`.
  - `bp_*` inputs are ignored.

## Test plan
- Reset, `imem_ack=1`, 1-cycle response latency, parcels `0x00100093`, `0x00200113` → `if_pc` 0x200 then 0x204, `if_bubble=0`, in order.
- `id_stall=1` for 6 cycles with the memory responding → at most 4 accepted requests; `if_*` held; after release, 4 consecutive instructions with no loss or duplication.
- 3 requests outstanding, `st_flush=1` with `st_nxt_pc=0x1000` → the 3 late responses are dropped; next `if_pc=0x1000`; `if_bubble=1` the cycle after the flush.
- `bu_flush` and `st_flush` in the same cycle (`bu_nxt_pc=0x300`, `st_nxt_pc=0x400`) → fetch resumes at 0x400.
- `imem_parcel_error=1` on PC 0x208 → `if_exception[1]=1`, `if_instr=0x00000013`, no further `imem_req` until a flush; then `bu_nxt_pc=0x202` → entry with `if_exception[0]=1` and no bus request.
- With `PU_RISCV_IF_BPREDICT_EN`, `bp_predict=2'b10`, `bp_nxt_pc=0x800` at PC 0x204 → next `imem_adr=0x800`; that instruction's `if_bp_predict=2'b10`.
